// File: rtl/qtree_bool_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : qtree_bool_stream_tx_if
//  Description : Bundle for the QTree_Bool stream serializer. It carries the
//                root pointer handshake, the heap read request and response,
//                and the output AXI-stream beat channel with the tree_done
//                pulse.
//                master : serializer side (drives root_ready, mem_req_*,
//                         o_t*, tree_done)
//                slave  : environment side (root source, heap, downstream)
//  Revision    : 1.0 - initial release
// ============================================================================
interface qtree_bool_stream_tx_if #(
    parameter int PTR_W  = 16,
    parameter int NODE_W = 66
);
    logic              root_valid;
    logic              root_ready;
    logic [PTR_W-1:0]  root_ptr;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [PTR_W-1:0]  mem_req_addr;
    logic              mem_rsp_valid;
    logic [NODE_W-1:0] mem_rsp_data;
    logic [NODE_W:0]   o_tdata;
    logic              o_tvalid;
    logic              o_tready;
    logic              o_tlast;
    logic              tree_done;

    modport master (
        input  root_valid, root_ptr, mem_req_ready, mem_rsp_valid, mem_rsp_data, o_tready,
        output root_ready, mem_req_valid, mem_req_addr, o_tdata, o_tvalid, o_tlast, tree_done
    );

    modport slave (
        output root_valid, root_ptr, mem_req_ready, mem_rsp_valid, mem_rsp_data, o_tready,
        input  root_ready, mem_req_valid, mem_req_addr, o_tdata, o_tvalid, o_tlast, tree_done
    );
endinterface
`default_nettype wire

// File: rtl/qtree_bool_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : qtree_bool_stream_tx
//  Description : Serializer for QTree_Bool heap structures. It takes a root
//                pointer, walks the tree through a single-outstanding heap
//                read port, and emits one beat per node in post-order
//                (child0..child3 subtrees, then the QNode itself). tlast
//                marks the root beat.
//  Ports       : clk            - clock, rising edge
//                reset          - asynchronous, active-high
//                bus (master)   - root_valid/ready/ptr, mem_req_valid/ready/
//                                 addr, mem_rsp_valid/data, o_tdata/tvalid/
//                                 tready/tlast, tree_done
//                beat_count     - beats emitted for the current tree
//                                 (only with QTREE_STREAM_TX_STATS_EN)
//  Options     : QTREE_STREAM_TX_STATS_EN adds the beat_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module qtree_bool_stream_tx #(
    parameter int PTR_W    = 16,
    parameter int NODE_W   = 66,
    parameter int STACK_AW = 8
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    qtree_bool_stream_tx_if.master      bus
`ifdef QTREE_STREAM_TX_STATS_EN
    ,
    output logic [15:0]                 beat_count
`endif
);
    localparam int c_DEPTH = 2 ** STACK_AW;
    localparam int c_CH_W  = 4 * PTR_W;
    localparam logic [STACK_AW:0]   c_FULL       = c_DEPTH[STACK_AW:0];
    localparam logic [NODE_W-1:0]   c_QNODE_BEAT = NODE_W'(2'b10);
    localparam logic [NODE_W-1:0]   c_QERR_BEAT  = NODE_W'(2'b11);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PTR_W-1:0]   r_cur;
    logic [STACK_AW:0]  r_sp;
    logic [NODE_W-1:0]  r_out;
    logic [c_CH_W-1:0]  r_stk_ch  [c_DEPTH];
    logic [2:0]         r_stk_idx [c_DEPTH];

    logic [STACK_AW-1:0] w_top_ptr;
    logic [c_CH_W-1:0]   w_top_ch;
    logic [2:0]          w_top_idx;
    logic [PTR_W-1:0]    w_child;
    logic                w_take_root;
    logic                w_push;
    logic                w_pop;
    logic                w_adv;
    logic                w_leaf;
    logic                w_err;

    // The top entry sits one below the stack pointer; when the stack is full
    // the low bits wrap to zero and the subtraction lands on the last slot.
    assign w_top_ptr = r_sp[STACK_AW-1:0] - 1'b1;
    assign w_top_ch  = r_stk_ch[w_top_ptr];
    assign w_top_idx = r_stk_idx[w_top_ptr];

    always_comb begin
        w_child = w_top_ch[0 +: PTR_W];
        case (w_top_idx[1:0])
            2'd1:    w_child = w_top_ch[1*PTR_W +: PTR_W];
            2'd2:    w_child = w_top_ch[2*PTR_W +: PTR_W];
            2'd3:    w_child = w_top_ch[3*PTR_W +: PTR_W];
            default: w_child = w_top_ch[0 +: PTR_W];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next            = r_state;
        w_take_root       = 1'b0;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_adv             = 1'b0;
        w_leaf            = 1'b0;
        w_err             = 1'b0;
        bus.root_ready    = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.o_tvalid      = 1'b0;
        bus.tree_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.root_ready = 1'b1;
                if (bus.root_valid) begin
                    w_take_root = 1'b1;
                    w_next      = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    if (bus.mem_rsp_data[1:0] == 2'd2) begin
                        if (r_sp == c_FULL) begin
                            w_err  = 1'b1;
                            w_next = S_EMIT;
                        end else begin
                            w_push = 1'b1;
                            w_next = S_NEXT;
                        end
                    end else begin
                        w_leaf = 1'b1;
                        w_next = S_EMIT;
                    end
                end
            end
            S_NEXT: begin
                if (!w_top_idx[2]) begin
                    w_adv  = 1'b1;
                    w_next = S_FETCH;
                end else begin
                    w_pop  = 1'b1;
                    w_next = S_EMIT;
                end
            end
            S_EMIT: begin
                bus.o_tvalid = 1'b1;
                if (bus.o_tready) begin
                    if (r_sp == '0) begin
                        bus.tree_done = 1'b1;
                        w_next        = S_IDLE;
                    end else if (!w_top_idx[2]) begin
                        // Advance straight to the next sibling fetch so a
                        // leaf costs FETCH/WAIT/EMIT only.
                        w_adv  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_pop  = 1'b1;
                        w_next = S_EMIT;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur <= '0;
            r_sp  <= '0;
            r_out <= '0;
        end else begin
            if (w_take_root) r_cur <= bus.root_ptr;
            if (w_adv)       r_cur <= w_child;
            if (w_push)      r_sp  <= r_sp + 1'b1;
            if (w_pop) begin
                r_sp  <= r_sp - 1'b1;
                r_out <= c_QNODE_BEAT;
            end
            if (w_leaf)      r_out <= bus.mem_rsp_data;
            if (w_err) begin
                // Overflow abandons the whole tree: the lone QError beat
                // becomes the root beat because the stack is now empty.
                r_sp  <= '0;
                r_out <= c_QERR_BEAT;
            end
        end
    end

    // Stack storage needs no reset; entries are only read below r_sp.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stk_ch[r_sp[STACK_AW-1:0]]  <= bus.mem_rsp_data[NODE_W-1:2];
            r_stk_idx[r_sp[STACK_AW-1:0]] <= 3'd0;
        end
        if (w_adv) r_stk_idx[w_top_ptr] <= w_top_idx + 3'd1;
    end

    assign bus.mem_req_addr = r_cur;
    assign bus.o_tdata      = (r_state == S_EMIT) ? {r_out, 1'b1} : '0;
    assign bus.o_tlast      = (r_state == S_EMIT) && (r_sp == '0);

`ifdef QTREE_STREAM_TX_STATS_EN
    logic [15:0] r_beat_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (w_take_root) begin
            r_beat_count <= '0;
        end else if ((r_state == S_EMIT) && bus.o_tready && (r_beat_count != 16'hFFFF)) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_qtree_bool_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qtree_bool_stream_tx
//  Description : Directed self-checking bench for qtree_bool_stream_tx with a
//                1-cycle-latency heap model. dut1 uses the default stack depth,
//                dut2 a two-entry stack for the overflow case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qtree_bool_stream_tx;
    localparam int PTR_W  = 16;
    localparam int NODE_W = 66;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    qtree_bool_stream_tx_if #(.PTR_W(PTR_W), .NODE_W(NODE_W)) bus1 ();
    qtree_bool_stream_tx_if #(.PTR_W(PTR_W), .NODE_W(NODE_W)) bus2 ();

`ifdef QTREE_STREAM_TX_STATS_EN
    logic [15:0] bc1, bc2;
`endif

    qtree_bool_stream_tx #(.PTR_W(PTR_W), .NODE_W(NODE_W), .STACK_AW(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
`ifdef QTREE_STREAM_TX_STATS_EN
        , .beat_count (bc1)
`endif
    );

    qtree_bool_stream_tx #(.PTR_W(PTR_W), .NODE_W(NODE_W), .STACK_AW(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
`ifdef QTREE_STREAM_TX_STATS_EN
        , .beat_count (bc2)
`endif
    );

    logic [NODE_W-1:0] mem [0:255];
    logic [67:0]       exp_q [$];
    int                n_cmp = 0;
    int                n_bad = 0;

    function automatic logic [NODE_W-1:0] qval(input logic b);
        return NODE_W'({b, 2'b01});
    endfunction

    function automatic logic [NODE_W-1:0] qnode(input logic [15:0] c0, input logic [15:0] c1,
                                               input logic [15:0] c2, input logic [15:0] c3);
        return {c3, c2, c1, c0, 2'b10};
    endfunction

    function automatic logic [67:0] beat(input logic last, input logic [66:0] d);
        return {last, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Heap models: sample a request handshake before the edge, answer one
    // cycle later for exactly one cycle.
    initial begin
        logic hs;
        logic [15:0] a;
        bus1.mem_rsp_valid = 1'b0;
        bus1.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus1.mem_req_valid && bus1.mem_req_ready;
            a  = bus1.mem_req_addr;
            @(posedge clk);
            #1;
            bus1.mem_rsp_valid = hs;
            bus1.mem_rsp_data  = hs ? mem[a[7:0]] : '0;
        end
    end

    initial begin
        logic hs;
        logic [15:0] a;
        bus2.mem_rsp_valid = 1'b0;
        bus2.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            hs = bus2.mem_req_valid && bus2.mem_req_ready;
            a  = bus2.mem_req_addr;
            @(posedge clk);
            #1;
            bus2.mem_rsp_valid = hs;
            bus2.mem_rsp_data  = hs ? mem[a[7:0]] : '0;
        end
    end

    // Offer a root to dut1 and consume beats against exp_q.
    task automatic run_tree1(input logic [15:0] root, input bit toggle, input string name);
        int          cyc;
        logic [67:0] e;
        @(negedge clk);
        #1;
        chk({name, " root_ready"}, bus1.root_ready, 1'b1);
        bus1.root_valid = 1'b1;
        bus1.root_ptr   = root;
        bus1.o_tready   = toggle ? 1'b0 : 1'b1;
        @(negedge clk);
        bus1.root_valid = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (toggle) bus1.o_tready = ~bus1.o_tready;
            #1;
            if (bus1.o_tvalid) begin
                e = exp_q[0];
                chk({name, " tdata"}, bus1.o_tdata, e[66:0]);
                chk({name, " tlast"}, bus1.o_tlast, e[67]);
                if (bus1.o_tready) begin
                    chk({name, " tree_done"}, bus1.tree_done, e[67]);
                    void'(exp_q.pop_front());
                end
            end
        end
        chk({name, " beats_left"}, exp_q.size(), 0);
        bus1.o_tready = 1'b1;
        @(negedge clk);
        #1;
        chk({name, " idle_root_ready"}, bus1.root_ready, 1'b1);
        chk({name, " idle_tvalid"}, bus1.o_tvalid, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h05] = qval(1'b1);
        mem[8'h10] = qnode(16'h11, 16'h12, 16'h13, 16'h14);
        mem[8'h11] = qval(1'b1);
        mem[8'h12] = qval(1'b0);
        mem[8'h13] = qval(1'b1);
        mem[8'h14] = qval(1'b0);
        mem[8'h20] = qnode(16'h21, 16'h26, 16'h27, 16'h28);
        mem[8'h21] = qnode(16'h22, 16'h23, 16'h24, 16'h25);
        mem[8'h22] = qval(1'b1);
        mem[8'h23] = qval(1'b1);
        mem[8'h24] = qval(1'b0);
        mem[8'h25] = qval(1'b0);
        mem[8'h26] = qval(1'b0);
        mem[8'h27] = '0;
        mem[8'h28] = NODE_W'(2'b11);
        mem[8'h30] = qnode(16'h31, 16'h11, 16'h11, 16'h11);
        mem[8'h31] = qnode(16'h32, 16'h11, 16'h11, 16'h11);
        mem[8'h32] = qnode(16'h11, 16'h12, 16'h13, 16'h14);

        reset = 1'b1;
        bus1.root_valid = 1'b0; bus1.root_ptr = '0; bus1.mem_req_ready = 1'b1; bus1.o_tready = 1'b1;
        bus2.root_valid = 1'b0; bus2.root_ptr = '0; bus2.mem_req_ready = 1'b1; bus2.o_tready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst root_ready", bus1.root_ready, 1'b1);
        chk("rst tvalid", bus1.o_tvalid, 1'b0);
        chk("rst mem_req_valid", bus1.mem_req_valid, 1'b0);
        chk("rst tlast_done_tdata", {bus1.o_tlast, bus1.tree_done, bus1.o_tdata}, '0);
        reset = 1'b0;

        // Single leaf root.
        exp_q.push_back(beat(1'b1, 67'hB));
        run_tree1(16'h05, 1'b0, "leaf");

        // One QNode with four leaves.
        exp_q.push_back(beat(1'b0, 67'hB));
        exp_q.push_back(beat(1'b0, 67'h3));
        exp_q.push_back(beat(1'b0, 67'hB));
        exp_q.push_back(beat(1'b0, 67'h3));
        exp_q.push_back(beat(1'b1, 67'h5));
        run_tree1(16'h10, 1'b0, "qnode4");

        // Depth-3 tree, streamed freely and then with tready toggling.
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.push_back(beat(1'b0, 67'hB));
            exp_q.push_back(beat(1'b0, 67'hB));
            exp_q.push_back(beat(1'b0, 67'h3));
            exp_q.push_back(beat(1'b0, 67'h3));
            exp_q.push_back(beat(1'b0, 67'h5));
            exp_q.push_back(beat(1'b0, 67'h3));
            exp_q.push_back(beat(1'b0, 67'h1));
            exp_q.push_back(beat(1'b0, 67'h7));
            exp_q.push_back(beat(1'b1, 67'h5));
            run_tree1(16'h20, pass == 1, pass == 1 ? "deep_stall" : "deep");
        end

        // Stack overflow on the two-entry instance.
        @(negedge clk);
        bus2.root_valid = 1'b1;
        bus2.root_ptr   = 16'h30;
        @(negedge clk);
        bus2.root_valid = 1'b0;
        cyc = 0;
        while (!bus2.o_tvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        chk("ovf tvalid", bus2.o_tvalid, 1'b1);
        chk("ovf tdata", bus2.o_tdata, 67'h7);
        chk("ovf tlast", bus2.o_tlast, 1'b1);
        chk("ovf tree_done", bus2.tree_done, 1'b1);
        @(negedge clk);
        #1;
        chk("ovf root_ready", bus2.root_ready, 1'b1);
        chk("ovf after tvalid", bus2.o_tvalid, 1'b0);

        // Reset while a beat is stalled in EMIT.
        @(negedge clk);
        bus1.o_tready   = 1'b0;
        bus1.root_valid = 1'b1;
        bus1.root_ptr   = 16'h05;
        @(negedge clk);
        bus1.root_valid = 1'b0;
        cyc = 0;
        while (!bus1.o_tvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            #1;
        end
        chk("abort pre tvalid", bus1.o_tvalid, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort tvalid", bus1.o_tvalid, 1'b0);
        chk("abort root_ready", bus1.root_ready, 1'b1);
        chk("abort tree_done", bus1.tree_done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        bus1.o_tready = 1'b1;
        exp_q.push_back(beat(1'b0, 67'hB));
        exp_q.push_back(beat(1'b0, 67'h3));
        exp_q.push_back(beat(1'b0, 67'hB));
        exp_q.push_back(beat(1'b0, 67'h3));
        exp_q.push_back(beat(1'b1, 67'h5));
        run_tree1(16'h10, 1'b0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
